bin2bcd_seq: RTL and testbench
==============================

# bin2bcd_seq

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It takes a BIN_W-bit binary word on a start strobe and returns DIGITS packed BCD digits with a done pulse. It sits between arithmetic/counter datapaths and the 7-segment display drivers, replacing unrolled combinational add-3 arrays where area matters more than latency.

## Interface
- BIN_W, 8, binary input width (≥ 2)
- DIGITS, 3, number of BCD output digits (≥ 1)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only when busy = 0
- bin_in  in  BIN_W  binary operand, sampled on the accepting edge
- busy  out  1  conversion in progress
- done  out  1  one-cycle pulse: bcd_out/ovf valid and updated
- bcd_out  out  4*DIGITS  packed BCD, digit 0 in bits [3:0]; held until the next done
- ovf  out  1  value not representable in DIGITS digits; held with bcd_out
- sign_out  out  1  only with BIN2BCD_SIGNED_EN; sign of the converted operand

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: busy = 0. When start = 1: load shift register ← bin_in, clear the BCD scratch, clear the sticky overflow, set count ← BIN_W, go to SHIFT.
- SHIFT: busy = 1. Each cycle does one combined step: every scratch digit ≥ 5 gets +3, then {scratch, shift register} shifts left by 1 and count decrements. A 1 shifted out of the top digit sets the sticky overflow. When count reaches 1, this step is the final step and the state goes to DONE.
- Final step: bcd_out ← final scratch, ovf ← sticky overflow, state → DONE.
- DONE: done = 1 and busy = 0 for exactly one cycle. A start seen in DONE is accepted exactly as in IDLE (back-to-back). Otherwise the state goes to IDLE.
- start while busy = 1 is ignored. It is not queued.
- Arithmetic:
  - The add-3 step works per 4-bit digit and is unsigned.
  - The scratch is exactly 4*DIGITS bits.
  - When ovf = 1, bcd_out holds the low DIGITS digits of the true result, modulo 10^DIGITS.
- Reset (async, any time, including mid-conversion): state IDLE, busy 0, done 0, bcd_out 0, ovf 0, sign_out 0, internal registers 0. The conversion in flight is discarded.

## Timing
- Edge E0 samples start = 1 with busy = 0. busy is high after E0 through E_BIN_W, i.e. for BIN_W cycles.
- done is high during the cycle after E_BIN_W. Start-to-done latency is BIN_W + 1 cycles.
- Maximum throughput is one conversion per BIN_W + 1 cycles, using start in the DONE cycle.
- bin_in need not be held after E0.
- Outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- BIN2BCD_SIGNED_EN defined:
  - bin_in is two's complement.
  - On acceptance the magnitude (|bin_in|, BIN_W-bit unsigned, so −2^(BIN_W−1) is exact) is loaded.
  - sign_out ← bin_in[BIN_W−1]. It updates together with bcd_out.
  - A zero result always gives sign_out = 0.
- BIN2BCD_SIGNED_EN undefined: bin_in is unsigned and the sign_out port does not exist.

## Structure
- Package bin2bcd_pkg holds:
  - state encoding constants (IDLE/SHIFT/DONE)
  - ADJ_THRESH = 5 and ADJ_ADD = 3
  - a count-width function clog2(BIN_W+1)
- Sub-module bcd_digit_adj: a purely combinational 4-bit "if ≥5 then +3" cell. It is instantiated DIGITS times via generate.
- The top holds the FSM, counter, shift register, scratch, and output registers.

## Test plan
- BIN_W=8, DIGITS=3, bin_in=255, start for one cycle → busy for 8 cycles, done in cycle 9, bcd_out=12'h255, ovf=0.
- bin_in=0 → bcd_out=12'h000 after 9 cycles. bin_in=99 → 12'h099.
- BIN_W=8, DIGITS=2, bin_in=100 → ovf=1, bcd_out=8'h00. bin_in=255 → ovf=1, bcd_out=8'h55.
- Start 200, then pulse start with 77 on cycle 4 (busy) → result 12'h200 with a single done. Start with 77 in the DONE cycle → next done 9 cycles later, bcd_out=12'h077.
- Assert rst on cycle 5 of a conversion of 123 → all outputs 0 immediately. No done appears. A subsequent start with 45 gives 12'h045.
- BIN2BCD_SIGNED_EN, BIN_W=8:
  - bin_in=8'h80 → sign_out=1, bcd_out=12'h128
  - bin_in=8'hFF → sign_out=1, bcd_out=12'h001
  - bin_in=0 → sign_out=0

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential double-dabble binary-to-BCD converter.
package bin2bcd_pkg;

  // Converter FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Per-digit adjust: a digit at or above ADJ_THRESH gets ADJ_ADD before the shift
  localparam int unsigned ADJ_THRESH = 5;
  localparam int unsigned ADJ_ADD    = 3;

  // Width of a down-counter that must hold the value bin_w
  function automatic int unsigned cnt_w(input int unsigned bin_w);
    return $clog2(bin_w + 1);
  endfunction

endpackage

// File: rtl/bin2bcd_seq_adj.sv
// bcd_digit_adj: combinational "if >= 5 then +3" cell for one BCD digit.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  // Add 3 so that the following left shift carries correctly into the next digit
  always_comb begin
    o_digit = i_digit;
    if (i_digit >= 4'(ADJ_THRESH)) begin
      o_digit = i_digit + 4'(ADJ_ADD);
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: one-bit-per-clock binary-to-BCD converter (shift-and-add-3).
// Optional feature macro: BIN2BCD_SIGNED_EN (two's complement input, adds sign_out).
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf
`ifdef BIN2BCD_SIGNED_EN
  ,
  output logic                  sign_out
`endif
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = cnt_w(BIN_W);

  state_e             r_state;
  logic [BIN_W-1:0]   r_sr;
  logic [BCD_W-1:0]   r_bcd;
  logic               r_ovf;
  logic [CNT_W-1:0]   r_cnt;

  logic [BCD_W-1:0]   w_adj;
  logic [BCD_W-1:0]   w_bcd_nxt;
  logic [BIN_W-1:0]   w_sr_nxt;
  logic               w_carry;
  logic               w_ovf_nxt;
  logic [BIN_W-1:0]   w_load;
  logic               w_last;

`ifdef BIN2BCD_SIGNED_EN
  logic               r_neg;

  // Magnitude of the two's complement operand; the most negative value maps exactly
  assign w_load = bin_in[BIN_W-1] ? (~bin_in + BIN_W'(1)) : bin_in;
`else
  assign w_load = bin_in;
`endif

  // One adjust cell per scratch digit
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit (r_bcd[4*g +: 4]),
      .o_digit (w_adj[4*g +: 4])
    );
  end

  // Combined step: adjusted scratch and shift register move left by one bit
  assign w_carry   = w_adj[BCD_W-1];
  assign w_bcd_nxt = {w_adj[BCD_W-2:0], r_sr[BIN_W-1]};
  assign w_sr_nxt  = {r_sr[BIN_W-2:0], 1'b0};
  assign w_ovf_nxt = r_ovf | w_carry;
  assign w_last    = (r_cnt == CNT_W'(1));

  // FSM, datapath registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_bcd   <= '0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
      ovf     <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
      r_neg    <= 1'b0;
      sign_out <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          // DONE accepts a new start exactly like IDLE for back-to-back use
          if (start) begin
            r_sr    <= w_load;
            r_bcd   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= CNT_W'(BIN_W);
            busy    <= 1'b1;
            r_state <= SHIFT;
`ifdef BIN2BCD_SIGNED_EN
            r_neg   <= bin_in[BIN_W-1];
`endif
          end else begin
            busy    <= 1'b0;
            r_state <= IDLE;
          end
        end
        SHIFT: begin
          r_bcd <= w_bcd_nxt;
          r_sr  <= w_sr_nxt;
          r_ovf <= w_ovf_nxt;
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_last) begin
            bcd_out <= w_bcd_nxt;
            ovf     <= w_ovf_nxt;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= DONE;
`ifdef BIN2BCD_SIGNED_EN
            // A negative operand never has zero magnitude, so zero stays positive
            sign_out <= r_neg;
`endif
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: two instances (3 and 2 digits) share stimulus.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  bin_in = 8'd0;

  logic        busy, done, ovf;
  logic [11:0] bcd_out;
  logic        busy2, done2, ovf2;
  logic [7:0]  bcd2;
`ifdef BIN2BCD_SIGNED_EN
  logic        sign_out, sign2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out), .ovf(ovf)
`ifdef BIN2BCD_SIGNED_EN
    , .sign_out(sign_out)
`endif
  );

  bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .busy(busy2), .done(done2), .bcd_out(bcd2), .ovf(ovf2)
`ifdef BIN2BCD_SIGNED_EN
    , .sign_out(sign2)
`endif
  );

  // Reference model: magnitude of the operand as an integer
  function automatic int mag_of(input logic [7:0] v);
`ifdef BIN2BCD_SIGNED_EN
    if (v[7]) return 256 - int'(v);
`endif
    return int'(v);
  endfunction

  // Reference model: low nd decimal digits of m, packed 4 bits each
  function automatic logic [11:0] bcd_of(input int m, input int nd);
    logic [11:0] r;
    int x;
    r = '0;
    x = m;
    for (int d = 0; d < nd; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Reference model: true when m needs more than nd decimal digits
  function automatic logic ovf_of(input int m, input int nd);
    int lim;
    lim = 1;
    for (int d = 0; d < nd; d++) lim = lim * 10;
    return m >= lim;
  endfunction

  // Pulse start with v (caller sits away from the rising edge); wait for done
  task automatic run_conv(input logic [7:0] v, output int lat, output int nbusy, output int nboth);
    start  = 1'b1;
    bin_in = v;
    @(posedge clk);
    #1;
    start  = 1'b0;
    bin_in = 8'($urandom);
    lat    = -1;
    nbusy  = 0;
    nboth  = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) begin
        lat = k;
        if (done2) nboth = 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_ctrl got busy=%b done=%b exp 0 0", busy, done); end
    checks++; if (bcd_out !== 12'h000 || ovf !== 1'b0) begin errors++; $display("FAIL reset_data got bcd=%h ovf=%b exp 000 0", bcd_out, ovf); end
    checks++; if (bcd2 !== 8'h00 || ovf2 !== 1'b0 || busy2 !== 1'b0 || done2 !== 1'b0) begin errors++; $display("FAIL reset_dut2 got bcd=%h ovf=%b busy=%b done=%b exp all 0", bcd2, ovf2, busy2, done2); end
`ifdef BIN2BCD_SIGNED_EN
    checks++; if (sign_out !== 1'b0 || sign2 !== 1'b0) begin errors++; $display("FAIL reset_sign got %b %b exp 0 0", sign_out, sign2); end
`endif
    rst = 1'b0;
  endtask

  // Conversions of a list of operands, each from idle, checked against the model
  task automatic test_convert(input int n, input logic rand_en);
    logic [7:0] vals [6];
    logic [7:0] v;
    int lat, nb, nboth, m;
    vals = '{8'd255, 8'd0, 8'd99, 8'd100, 8'd37, 8'd128};
    for (int i = 0; i < n; i++) begin
      v = rand_en ? 8'($urandom) : vals[i % 6];
      m = mag_of(v);
      @(negedge clk);
      run_conv(v, lat, nb, nboth);
      checks++; if (lat !== 9) begin errors++; $display("FAIL latency v=%0d got %0d exp 9", v, lat); end
      checks++; if (nb !== 8) begin errors++; $display("FAIL busy_len v=%0d got %0d exp 8", v, nb); end
      checks++; if (nboth !== 1) begin errors++; $display("FAIL done2_align v=%0d got %0d exp 1", v, nboth); end
      checks++; if (bcd_out !== bcd_of(m, 3)) begin errors++; $display("FAIL bcd3 v=%0d got %h exp %h", v, bcd_out, bcd_of(m, 3)); end
      checks++; if (ovf !== ovf_of(m, 3)) begin errors++; $display("FAIL ovf3 v=%0d got %b exp %b", v, ovf, ovf_of(m, 3)); end
      checks++; if (bcd2 !== 8'(bcd_of(m, 2))) begin errors++; $display("FAIL bcd2 v=%0d got %h exp %h", v, bcd2, 8'(bcd_of(m, 2))); end
      checks++; if (ovf2 !== ovf_of(m, 2)) begin errors++; $display("FAIL ovf2 v=%0d got %b exp %b", v, ovf2, ovf_of(m, 2)); end
`ifdef BIN2BCD_SIGNED_EN
      checks++; if (sign_out !== v[7] || sign2 !== v[7]) begin errors++; $display("FAIL sign v=%0d got %b %b exp %b", v, sign_out, sign2, v[7]); end
`endif
    end
  endtask

  // Start while busy must be dropped, giving exactly one done with the first result
  task automatic test_busy_ignore;
    int ndone, at;
    logic [11:0] got;
    @(negedge clk);
    start  = 1'b1;
    bin_in = 8'd200;
    @(posedge clk);
    #1;
    start  = 1'b0;
    ndone  = 0;
    at     = -1;
    got    = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 4) begin start = 1'b1; bin_in = 8'd77; end
      else start = 1'b0;
      if (done) begin ndone++; at = k; got = bcd_out; end
    end
    start = 1'b0;
    checks++; if (ndone !== 1) begin errors++; $display("FAIL ignore_ndone got %0d exp 1", ndone); end
    checks++; if (at !== 9) begin errors++; $display("FAIL ignore_at got %0d exp 9", at); end
    checks++; if (got !== bcd_of(mag_of(8'd200), 3)) begin errors++; $display("FAIL ignore_bcd got %h exp %h", got, bcd_of(mag_of(8'd200), 3)); end
  endtask

  // Start issued in the DONE cycle is accepted immediately
  task automatic test_back_to_back;
    int lat, nb, nboth;
    @(negedge clk);
    run_conv(8'd31, lat, nb, nboth);
    checks++; if (bcd_out !== bcd_of(mag_of(8'd31), 3)) begin errors++; $display("FAIL b2b_first got %h exp %h", bcd_out, bcd_of(mag_of(8'd31), 3)); end
    run_conv(8'd77, lat, nb, nboth);
    checks++; if (lat !== 9) begin errors++; $display("FAIL b2b_latency got %0d exp 9", lat); end
    checks++; if (nb !== 8) begin errors++; $display("FAIL b2b_busy got %0d exp 8", nb); end
    checks++; if (bcd_out !== bcd_of(mag_of(8'd77), 3)) begin errors++; $display("FAIL b2b_second got %h exp %h", bcd_out, bcd_of(mag_of(8'd77), 3)); end
  endtask

  // Async reset mid-conversion clears outputs at once and discards the conversion
  task automatic test_reset_mid;
    int nd, lat, nb, nboth;
    @(negedge clk);
    start  = 1'b1;
    bin_in = 8'd123;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 5; k++) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before got %b exp 1", busy); end
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== 12'h000 || ovf !== 1'b0) begin errors++; $display("FAIL rmid_clear got busy=%b done=%b bcd=%h ovf=%b exp 0 0 000 0", busy, done, bcd_out, ovf); end
    checks++; if (busy2 !== 1'b0 || bcd2 !== 8'h00 || ovf2 !== 1'b0) begin errors++; $display("FAIL rmid_clear2 got busy=%b bcd=%h ovf=%b exp 0 00 0", busy2, bcd2, ovf2); end
    @(negedge clk);
    rst = 1'b0;
    nd  = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done || done2) nd++;
    end
    checks++; if (nd !== 0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_no_done got dones=%0d busy=%b exp 0 0", nd, busy); end
    run_conv(8'd45, lat, nb, nboth);
    checks++; if (lat !== 9 || bcd_out !== bcd_of(mag_of(8'd45), 3)) begin errors++; $display("FAIL rmid_after got lat=%0d bcd=%h exp 9 %h", lat, bcd_out, bcd_of(mag_of(8'd45), 3)); end
  endtask

`ifdef BIN2BCD_SIGNED_EN
  // Signed operands including the most negative value
  task automatic test_signed;
    int lat, nb, nboth;
    @(negedge clk);
    run_conv(8'h80, lat, nb, nboth);
    checks++; if (sign_out !== 1'b1 || bcd_out !== 12'h128) begin errors++; $display("FAIL signed_80 got sign=%b bcd=%h exp 1 128", sign_out, bcd_out); end
    checks++; if (ovf2 !== 1'b1 || bcd2 !== 8'h28 || sign2 !== 1'b1) begin errors++; $display("FAIL signed_80_d2 got ovf=%b bcd=%h sign=%b exp 1 28 1", ovf2, bcd2, sign2); end
    @(negedge clk);
    run_conv(8'hFF, lat, nb, nboth);
    checks++; if (sign_out !== 1'b1 || bcd_out !== 12'h001) begin errors++; $display("FAIL signed_ff got sign=%b bcd=%h exp 1 001", sign_out, bcd_out); end
    @(negedge clk);
    run_conv(8'h00, lat, nb, nboth);
    checks++; if (sign_out !== 1'b0 || bcd_out !== 12'h000) begin errors++; $display("FAIL signed_zero got sign=%b bcd=%h exp 0 000", sign_out, bcd_out); end
  endtask
`endif

  initial begin
    test_reset();
    test_convert(6, 1'b0);
    test_convert(25, 1'b1);
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
`ifdef BIN2BCD_SIGNED_EN
    test_signed();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
